// File: rtl/fetch_sequencer_pkg.sv
//-----------------------------------------------------------------------------
// Module   : fetch_sequencer_pkg
// Purpose  : Shared definitions for the instruction-fetch controller:
//            FSM state encodings, PC increment and reset PC default.
// Ports    : none (package)
// Config   : `WORD_WIDTH sets the default address/instruction width (32).
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int PC_STEP = 4;

  localparam logic [`WORD_WIDTH-1:0] RESET_PC_DEFAULT = '0;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
//-----------------------------------------------------------------------------
// Module   : fetch_queue
// Purpose  : Synchronous FIFO of {pc, instr} entries feeding decode. Flush
//            empties the queue and takes priority over push and pop.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            push, push_pc, push_instr - enqueue one entry
//            pop              - drop the head entry
//            flush            - discard all entries
//            count            - number of valid entries (0..QDEPTH)
//            head_pc, head_instr - head entry, read straight from storage
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
  parameter int WORD_WIDTH = 32,
  parameter int QDEPTH     = 2,
  localparam int AW        = $clog2(QDEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_pc,
  input  logic [WORD_WIDTH-1:0] push_instr,
  input  logic                  pop,
  input  logic                  flush,
  output logic [CW-1:0]         count,
  output logic [WORD_WIDTH-1:0] head_pc,
  output logic [WORD_WIDTH-1:0] head_instr
);

  logic [WORD_WIDTH-1:0] pc_mem    [QDEPTH];
  logic [WORD_WIDTH-1:0] instr_mem [QDEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; only the pointers define validity. When full
  // with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
//-----------------------------------------------------------------------------
// Module   : fetch_sequencer
// Purpose  : Instruction-fetch controller. Owns the PC, addresses a
//            zero-latency instruction memory, buffers fetched words in a
//            small queue and hands them to decode with valid/ready.
//            Supports branch redirect/flush, start and halt.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start, halt_req   - run control
//            imem_addr/instr   - instruction memory (combinational read)
//            id_valid/ready/instr/pc - decode handshake
//            br_taken, br_addr - redirect from execute
//            halted, state_o   - status / debug
// Config   : ZERO_HALT_EN - when defined, an all-zero fetched word in RUN
//            is dropped, pc holds and the FSM moves to HALT.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                    WORD_WIDTH = `WORD_WIDTH,
  parameter int                    QDEPTH     = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = WORD_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic [WORD_WIDTH-1:0] imem_instr,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [WORD_WIDTH-1:0] id_instr,
  output logic [WORD_WIDTH-1:0] id_pc,
  input  logic                  br_taken,
  input  logic [WORD_WIDTH-1:0] br_addr,
  input  logic                  halt_req,
  output logic                  halted,
  output logic [1:0]            state_o
);

  localparam int            CW   = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  state_t                state;
  logic [WORD_WIDTH-1:0] pc;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  fetch_ok;
  logic                  zero_stop;
  logic                  push;
  logic                  flush;
  logic                  unused_br_lsbs;

  assign unused_br_lsbs = ^br_addr[1:0];

  assign imem_addr = pc;
  assign id_valid  = (count != '0);
  assign pop       = id_valid && id_ready;

  // A slot is available if the queue is not full or the head leaves now.
  assign fetch_ok  = (state == ST_RUN) && !br_taken && ((count < FULL) || pop);

`ifdef ZERO_HALT_EN
  assign zero_stop = fetch_ok && (imem_instr == '0);
`else
  assign zero_stop = 1'b0;
`endif

  assign push  = fetch_ok && !zero_stop;
  // A redirect in IDLE is ignored entirely.
  assign flush = br_taken && (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      if (flush) begin
        pc <= {br_addr[WORD_WIDTH-1:2], 2'b00};
      end else if (push) begin
        pc <= pc + WORD_WIDTH'(PC_STEP);
      end

      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN:  if (halt_req || zero_stop) state <= ST_HALT;
        ST_HALT: if (start && !halt_req) state <= ST_RUN;
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .WORD_WIDTH (WORD_WIDTH),
    .QDEPTH     (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (pc),
    .push_instr (imem_instr),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_pc    (id_pc),
    .head_instr (id_instr)
  );

  assign halted  = (state == ST_HALT) && (count == '0);
  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//-----------------------------------------------------------------------------
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer: directed scenarios
//            plus randomized run against a queue-based reference model.
// Config   : honours ZERO_HALT_EN for the zero-word expectations.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  localparam int QD = 2;
`ifdef ZERO_HALT_EN
  localparam bit ZH = 1'b1;
`else
  localparam bit ZH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, id_ready, br_taken, halt_req;
  logic [31:0] br_addr, imem_addr, imem_instr, id_instr, id_pc;
  logic        id_valid, halted;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .halt_req   (halt_req),
    .halted     (halted),
    .state_o    (state_o)
  );

  // Instruction memory: 64 programmable words, a nonzero pattern elsewhere.
  logic [31:0] mem_arr [64];

  always_comb begin
    if (imem_addr < 32'd256) imem_instr = mem_arr[imem_addr[7:2]];
    else                     imem_instr = imem_addr ^ 32'h5A5A_0001;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256) return mem_arr[a[7:2]];
    return a ^ 32'h5A5A_0001;
  endfunction

  // Reference model: mode 0=idle 1=run 2=halt, queue of fetched entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_mode;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Advance one clock, updating the model from the inputs held across it.
  task automatic cycle();
    bit          do_pop, do_push, do_flush, zh;
    logic [31:0] word;
    ent_t        e;
    word     = mem_word(m_pc);
    do_pop   = (mq.size() != 0) && id_ready;
    do_flush = br_taken && (m_mode != 0);
    do_push  = (m_mode == 1) && !br_taken && ((mq.size() < QD) || do_pop);
    zh       = ZH && do_push && (word == 32'h0);
    if (zh) do_push = 1'b0;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pc   = 32'h0;
      m_mode = 0;
    end else begin
      if (do_flush) begin
        mq.delete();
        m_pc = br_addr & 32'hFFFF_FFFC;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.pc    = m_pc;
          e.instr = word;
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
      case (m_mode)
        0:       if (start) m_mode = 1;
        1:       if (halt_req || zh) m_mode = 2;
        default: if (start && !halt_req) m_mode = 1;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; br_taken = 1'b0; halt_req = 1'b0;
    id_ready = 1'b0; br_addr = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; br_taken = 1'b1; br_addr = 32'h40; halt_req = 1'b0;
    id_ready = 1'b1;
    cycle();
    rst = 1'b0; start = 1'b0; br_taken = 1'b0;
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected 00000000", imem_addr); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    id_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    n_cmp++; if (state_o !== 2'd1) begin n_bad++; $display("FAIL basic_run: got %0d expected 1", state_o); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL basic_nofetch_yet: got %b expected 0", id_valid); end
    cycle();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hE3A0_0014) begin
      n_bad++; $display("FAIL basic_first: got v=%b pc=%h i=%h expected v=1 pc=00000000 i=e3a00014", id_valid, id_pc, id_instr);
    end
    cycle();
    n_cmp++; if (id_pc !== 32'h4 || id_instr !== 32'hE3A0_1A01) begin
      n_bad++; $display("FAIL basic_second: got pc=%h i=%h expected pc=00000004 i=e3a01a01", id_pc, id_instr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    n_cmp++; if (imem_addr !== 32'h8 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_full: got addr=%h head=%h v=%b expected addr=00000008 head=00000000 v=1", imem_addr, id_pc, id_valid);
    end
    id_ready = 1'b1;
    cycle();
    n_cmp++; if (id_pc !== 32'h4 || id_valid !== 1'b1) begin n_bad++; $display("FAIL bp_second: got %h expected 00000004", id_pc); end
    cycle();
    n_cmp++; if (id_pc !== 32'h8 || id_valid !== 1'b1) begin n_bad++; $display("FAIL bp_third: got %h expected 00000008", id_pc); end
  endtask

  task automatic test_branch();
    id_ready = 1'b0;
    repeat (3) cycle();
    br_taken = 1'b1; br_addr = 32'h0000_0013;
    cycle();
    br_taken = 1'b0;
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 32'h10) begin
      n_bad++; $display("FAIL br_flush: got v=%b addr=%h expected v=0 addr=00000010", id_valid, imem_addr);
    end
    cycle();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== mem_arr[4]) begin
      n_bad++; $display("FAIL br_target: got v=%b pc=%h i=%h expected v=1 pc=00000010 i=%h", id_valid, id_pc, id_instr, mem_arr[4]);
    end
  endtask

  task automatic test_wrap();
    id_ready = 1'b1; br_taken = 1'b1; br_addr = 32'hFFFF_FFFF;
    cycle();
    br_taken = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_target: got %h expected fffffffc", imem_addr); end
    cycle();
    n_cmp++; if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'hA5A5_FFFD) begin
      n_bad++; $display("FAIL wrap_fetch: got addr=%h pc=%h i=%h expected addr=00000000 pc=fffffffc i=a5a5fffd", imem_addr, id_pc, id_instr);
    end
    cycle();
    n_cmp++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_next: got %h expected 00000000", id_pc); end
  endtask

  task automatic test_halt();
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    id_ready = 1'b1; halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    n_cmp++; if (state_o !== 2'd2 || halted !== 1'b0 || imem_addr !== 32'hC) begin
      n_bad++; $display("FAIL halt_enter: got st=%0d h=%b addr=%h expected st=2 h=0 addr=0000000c", state_o, halted, imem_addr);
    end
    repeat (2) cycle();
    n_cmp++; if (halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'hC) begin
      n_bad++; $display("FAIL halt_drained: got h=%b v=%b addr=%h expected h=1 v=0 addr=0000000c", halted, id_valid, imem_addr);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_cmp++; if (state_o !== 2'd1 || halted !== 1'b0) begin n_bad++; $display("FAIL halt_restart: got st=%0d h=%b expected st=1 h=0", state_o, halted); end
    cycle();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'hC) begin n_bad++; $display("FAIL halt_resume: got v=%b pc=%h expected v=1 pc=0000000c", id_valid, id_pc); end
  endtask

  task automatic test_zero_word();
    logic [31:0] saved;
    saved = mem_arr[3];
    mem_arr[3] = 32'h0;
    do_reset();
    id_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * k)) begin
        n_bad++; $display("FAIL zero_seq%0d: got v=%b pc=%h expected v=1 pc=%h", k, id_valid, id_pc, 32'(4 * k));
      end
    end
    cycle();
    if (ZH) begin
      n_cmp++; if (state_o !== 2'd2 || halted !== 1'b1 || imem_addr !== 32'hC) begin
        n_bad++; $display("FAIL zero_halt: got st=%0d h=%b addr=%h expected st=2 h=1 addr=0000000c", state_o, halted, imem_addr);
      end
    end else begin
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== 32'h0) begin
        n_bad++; $display("FAIL zero_enqueue: got v=%b pc=%h i=%h expected v=1 pc=0000000c i=00000000", id_valid, id_pc, id_instr);
      end
    end
    mem_arr[3] = saved;
  endtask

  task automatic test_random();
    mem_arr[7] = 32'h0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      start    = ($urandom_range(0, 9) < 2);
      halt_req = ($urandom_range(0, 19) == 0);
      br_taken = ($urandom_range(0, 9) == 0);
      id_ready = ($urandom_range(0, 9) < 6);
      br_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 255));
      cycle();
      n_cmp++; if (id_valid !== (mq.size() != 0)) begin
        n_bad++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, id_valid, (mq.size() != 0));
      end
      if (mq.size() != 0) begin
        n_cmp++; if (id_pc !== mq[0].pc || id_instr !== mq[0].instr) begin
          n_bad++; $display("FAIL rnd_head@%0d: got pc=%h i=%h expected pc=%h i=%h", n, id_pc, id_instr, mq[0].pc, mq[0].instr);
        end
      end
      n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_pc@%0d: got %h expected %h", n, imem_addr, m_pc); end
      n_cmp++; if (state_o !== 2'(m_mode) || halted !== ((m_mode == 2) && (mq.size() == 0))) begin
        n_bad++; $display("FAIL rnd_state@%0d: got st=%0d h=%b expected st=%0d h=%b", n, state_o, halted, m_mode, ((m_mode == 2) && (mq.size() == 0)));
      end
    end
    rst = 1'b0; start = 1'b0; halt_req = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom | 32'h1;
    mem_arr[0] = 32'hE3A0_0014;
    mem_arr[1] = 32'hE3A0_1A01;
    rst = 1'b1; start = 1'b0; br_taken = 1'b0; halt_req = 1'b0;
    id_ready = 1'b0; br_addr = '0;
    m_pc = '0; m_mode = 0;
    #1;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_branch();
    test_wrap();
    test_halt();
    test_zero_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the combinational instruction memory. It owns the program counter, drives the memory address and captures each returned word into a small instruction queue. It presents instructions to decode with a valid/ready handshake and handles branch redirect/flush, start and halt.

Parameters:
WORD_WIDTH, `WORD_WIDTH (32), width of addresses and instruction words
QDEPTH, 2, instruction queue depth (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  leave IDLE/HALT and begin fetching
imem_addr  output  WORD_WIDTH  byte address to instruction memory (= pc)
imem_instr  input  WORD_WIDTH  instruction word, combinational from imem_addr
id_valid  output  1  queue head valid to decode
id_ready  input  1  decode accepts head this cycle
id_instr  output  WORD_WIDTH  queue head instruction
id_pc  output  WORD_WIDTH  fetch address of queue head
br_taken  input  1  redirect request from execute
br_addr  input  WORD_WIDTH  redirect target
halt_req  input  1  stop fetching
halted  output  1  high in HALT with queue empty
state_o  output  2  current FSM state (debug)

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, queue emptied, state<=IDLE. id_valid=0, halted=0, state_o=IDLE. rst overrides all inputs, including mid-branch.
- imem_addr=pc at all times. Memory is zero-latency: the word is sampled at the same edge.
- FSM states: IDLE(0), RUN(1), HALT(2).
  - IDLE: no fetch. start -> RUN.
  - RUN: fetch when push allowed. halt_req -> HALT. If halt_req and start are both high, halt_req wins.
  - HALT: no fetch, pops still allowed. start (with halt_req low) -> RUN, resuming at the current pc.
- Push allowed: state==RUN, br_taken=0, and (count<QDEPTH or pop this cycle).
- On push: enqueue {pc, imem_instr}, pc<=pc+4 modulo 2^WORD_WIDTH. 0xFFFFFFFC wraps to 0.
- Pop: id_valid && id_ready. Head advances at the edge.
- Push and pop together at full: allowed, count unchanged.
- id_valid = (count!=0). id_instr/id_pc are driven from the head combinationally from the queue registers. No memory-to-decode combinational path.
- Fetch-to-decode latency: 1 cycle (word sampled at edge t, id_valid at t+1).
- br_taken (any state except IDLE):
  - At the edge: queue flushed (count<=0), pc<={br_addr[WORD_WIDTH-1:2],2'b00}, no push.
  - A same-cycle pop is discarded (flush dominates). id_valid=0 the next cycle.
  - Fetch of the target occurs the cycle after br_taken if state==RUN.
  - State is unchanged.
- br_taken in IDLE: ignored.
- halted = (state==HALT) && (count==0).
- Queue full with id_ready=0: pc holds, no fetch, no memory side effects.

Optional Feature:
ZERO_HALT_EN
- Defined: in RUN, a fetched word equal to all-zeros (unprogrammed memory) is not enqueued, pc holds, and state<=HALT at that edge.
- Not defined: zero words are fetched and enqueued like any other instruction.

Decomposition:
- Shared package (settings header extension): FSM state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2), PC_STEP=4, reset PC default.
- Sub-module fetch_queue: synchronous FIFO of {pc, instr} entries.
  - Ports: push, pop, flush, count, head outputs.
  - Flush has priority over push and pop.
- FSM and pc logic stay in fetch_sequencer.

Test Plan:
- Reset then start, id_ready=1, memory[0]=32'hE3A00014, memory[4]=32'hE3A01A01 -> cycle after start edge: id_valid=1, id_pc=0, id_instr=E3A00014. Next cycle: id_pc=4, id_instr=E3A01A01.
- id_ready=0 for 5 cycles after start -> queue fills at QDEPTH=2, pc holds at 8, id_pc stays 0. On releasing ready, entries 0 and 4 then 8 appear in order with no gaps.
- br_taken=1, br_addr=32'h0000_0013 while queue holds 2 entries -> next cycle id_valid=0, pc=0x10. Following cycle id_pc=0x10.
- pc=32'hFFFF_FFFC fetch -> next pc=0, no stall.
- halt_req mid-run with 2 queued and id_ready=1 -> no new fetches, halted=1 after both drain. start -> fetch resumes at held pc.
- With ZERO_HALT_EN, memory[12]=0 -> entries 0,4,8 delivered, state_o=HALT, halted=1, pc=12. Without the macro -> zero word delivered at id_pc=12.
